// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch/data) round-robin arbiter in front of a single APB-style master port.
// Stalled slaves are cut off after TIMEOUT wait cycles and the transfer completes with bus_err.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_strb,
  output logic [31:0] d_rdata,
  output logic        d_ready,

  output logic        bus_err,

  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic [31:0] prdata,
  input  logic        pready
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE
  } state_e;

  localparam logic       REQ_IF    = 1'b0;
  localparam logic       REQ_D     = 1'b1;
  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  state_e      state_q;
  state_e      state_d;
  logic        last_q;
  logic        gnt_q;
  logic [7:0]  wait_q;
  logic [7:0]  wait_inc;
  logic        grant;
  logic        grant_sel;
  logic        timeout_hit;
  logic        xfer_end;
  logic [31:0] xfer_rdata;

  // Saturating increment: the counter sticks at its maximum instead of wrapping.
  assign wait_inc    = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
  assign timeout_hit = (state_q == ST_ACCESS) && !pready && (wait_inc == TIMEOUT_W);
  assign xfer_end    = (state_q == ST_ACCESS) && (pready || timeout_hit);
  assign xfer_rdata  = (pready && !pwrite) ? prdata : 32'h0;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    grant_sel = REQ_IF;
    psel      = 1'b0;
    penable   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          grant   = 1'b1;
          state_d = ST_SETUP;
          // Under contention the requester that was not served last goes next.
          if (if_req && d_req) grant_sel = ~last_q;
          else                 grant_sel = d_req ? REQ_D : REQ_IF;
        end
      end
      ST_SETUP: begin
        psel    = 1'b1;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (xfer_end) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= REQ_D;
      gnt_q  <= REQ_IF;
    end else if (grant) begin
      last_q <= grant_sel;
      gnt_q  <= grant_sel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q <= 8'h00;
    end else if (grant) begin
      wait_q <= 8'h00;
    end else if ((state_q == ST_ACCESS) && !pready) begin
      wait_q <= wait_inc;
    end
  end

  // Winner's request is captured at grant; the requester may change its inputs freely afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      paddr  <= 32'h0;
      pwdata <= 32'h0;
      pstrb  <= 4'b0000;
      pwrite <= 1'b0;
    end else if (grant) begin
      if (grant_sel == REQ_D) begin
        paddr  <= d_addr;
        pwdata <= d_wdata;
        pstrb  <= d_we ? d_strb : 4'b0000;
        pwrite <= d_we;
      end else begin
        paddr  <= if_addr;
        pwdata <= 32'h0;
        pstrb  <= 4'b0000;
        pwrite <= 1'b0;
      end
    end
  end

  // Ready/bus_err are registered on the ACCESS->DONE edge, so they are high exactly during DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      bus_err  <= 1'b0;
      if_rdata <= 32'h0;
      d_rdata  <= 32'h0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      bus_err  <= 1'b0;
      if (xfer_end) begin
        bus_err <= !pready;
        if (gnt_q == REQ_D) begin
          d_ready <= 1'b1;
          d_rdata <= xfer_rdata;
        end else begin
          if_ready <= 1'b1;
          if_rdata <= xfer_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: stimulus pushes expected completions into a scoreboard,
// a negedge monitor pops and compares them whenever a ready pulse appears.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_strb;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        bus_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;

  mem_bus_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_strb   (d_strb),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .bus_err  (bus_err),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pstrb    (pstrb),
    .prdata   (prdata),
    .pready   (pready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (reset && (if_ready || d_ready)) begin
      check("ready_exclusive", 32'(if_ready & d_ready), 32'd0);
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready: got if_ready=%0b d_ready=%0b expected no completion", if_ready, d_ready);
      end else begin
        e = sb_q.pop_front();
        check("ready_id", 32'(d_ready), 32'(e.id));
        check("rdata", d_ready ? d_rdata : if_rdata, e.rdata);
        check("bus_err", 32'(bus_err), 32'(e.err));
      end
    end
  end

  // Called one delta after a rising edge with the FSM in IDLE and requests already driven.
  task automatic run_xfer(
    input string       name,
    input logic        exp_id,
    input int          waits,
    input logic [31:0] slave_rdata,
    input logic [31:0] exp_addr,
    input logic        exp_write,
    input logic [31:0] exp_wdata,
    input logic [3:0]  exp_strb,
    input logic [31:0] exp_rdata,
    input logic        exp_err,
    input int          exp_lat,
    input bit          drop_after_grant,
    input bit          poke_other
  );
    int   k;
    int   acc;
    bit   seen;
    exp_t e;
    e.id = exp_id; e.rdata = exp_rdata; e.err = exp_err;
    sb_q.push_back(e);
    k = -1; acc = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      pready = 1'b0;
      if (k == 1) begin
        check({name, "_setup_psel"},    32'(psel),    32'd1);
        check({name, "_setup_penable"}, 32'(penable), 32'd0);
        check({name, "_setup_paddr"},   paddr,        exp_addr);
        check({name, "_setup_pwrite"},  32'(pwrite),  32'(exp_write));
        check({name, "_setup_pstrb"},   32'(pstrb),   32'(exp_strb));
        if (exp_write) check({name, "_setup_pwdata"}, pwdata, exp_wdata);
        if (drop_after_grant) begin
          if (exp_id) d_req = 1'b0; else if_req = 1'b0;
          if_addr = ~if_addr; d_addr = ~d_addr; d_wdata = ~d_wdata;
          d_strb  = ~d_strb;  d_we   = ~d_we;
        end
        if (poke_other) begin
          if (exp_id) if_req = 1'b1; else d_req = 1'b1;
        end
      end
      if (k == 2) begin
        check({name, "_access_psel"},    32'(psel),    32'd1);
        check({name, "_access_penable"}, 32'(penable), 32'd1);
        check({name, "_access_paddr"},   paddr,        exp_addr);
        check({name, "_access_pwrite"},  32'(pwrite),  32'(exp_write));
        check({name, "_access_pstrb"},   32'(pstrb),   32'(exp_strb));
        if (poke_other) begin
          if (exp_id) if_req = 1'b0; else d_req = 1'b0;
        end
      end
      if (if_ready || d_ready) begin
        seen = 1'b1;
      end else if (penable) begin
        acc++;
        pready = (acc > waits);
        prdata = slave_rdata;
      end
    end
    check({name, "_latency"}, k, exp_lat);
    check({name, "_done_psel"}, 32'(psel), 32'd0);
    if (exp_id) d_req = 1'b0; else if_req = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got no end of test expected completion within 20000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    reset = 1'b0; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; d_strb = 4'h0; prdata = 32'h0; pready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_psel",     32'(psel),     32'd0);
    check("rst_penable",  32'(penable),  32'd0);
    check("rst_pwrite",   32'(pwrite),   32'd0);
    check("rst_if_ready", 32'(if_ready), 32'd0);
    check("rst_d_ready",  32'(d_ready),  32'd0);
    check("rst_bus_err",  32'(bus_err),  32'd0);
    check("rst_paddr",    paddr,         32'h0);
    check("rst_pwdata",   pwdata,        32'h0);
    check("rst_pstrb",    32'(pstrb),    32'd0);
    check("rst_if_rdata", if_rdata,      32'h0);
    check("rst_d_rdata",  d_rdata,       32'h0);
    @(posedge clk); #1; reset = 1'b1;

    // Zero-wait fetch
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0000_0010;
    run_xfer("fetch0", 1'b0, 0, 32'h0050_0093, 32'h0000_0010, 1'b0, 32'h0, 4'h0,
             32'h0050_0093, 1'b0, 3, 1'b0, 1'b0);

    // Store with two wait states; a fetch request pulses only while busy and must be ignored
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000_0004; d_wdata = 32'hDEAD_BEEF; d_strb = 4'hF;
    run_xfer("store", 1'b1, 2, 32'h1111_2222, 32'h1000_0004, 1'b1, 32'hDEAD_BEEF, 4'hF,
             32'h0, 1'b0, 5, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_after_poke", 32'(psel), 32'd0);
    end

    // Load whose requester drops and scrambles its inputs right after grant
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000_0008; d_wdata = 32'h5555_5555; d_strb = 4'hA;
    run_xfer("load_drop", 1'b1, 1, 32'h1234_5678, 32'h2000_0008, 1'b0, 32'h0, 4'h0,
             32'h1234_5678, 1'b0, 4, 1'b1, 1'b0);

    // Fetch completion must leave d_rdata untouched
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0000_0100;
    run_xfer("fetch1", 1'b0, 0, 32'hCAFE_F00D, 32'h0000_0100, 1'b0, 32'h0, 4'h0,
             32'hCAFE_F00D, 1'b0, 3, 1'b0, 1'b0);
    check("d_rdata_hold", d_rdata, 32'h1234_5678);

    // Slave never ready: 15 ACCESS cycles then error completion with zero data
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000_0010; d_strb = 4'h0;
    run_xfer("timeout", 1'b1, 255, 32'hFFFF_FFFF, 32'h2000_0010, 1'b0, 32'h0, 4'h0,
             32'h0, 1'b1, 17, 1'b0, 1'b0);
    check("timeout_d_rdata", d_rdata, 32'h0);
    @(negedge clk);
    check("timeout_err_clear", 32'(bus_err), 32'd0);
    check("timeout_idle_psel", 32'(psel),    32'd0);
    check("timeout_d_ready",   32'(d_ready), 32'd0);

    // Reset in the middle of ACCESS
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000_0000;
    k = 0;
    while (!penable && k < 6) begin
      @(negedge clk);
      k++;
    end
    check("mid_reach_access", 32'(penable), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_psel",    32'(psel),    32'd0);
    check("mid_rst_penable", 32'(penable), 32'd0);
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0044;
    repeat (2) @(negedge clk);
    check("mid_rst_if_ready", 32'(if_ready), 32'd0);
    check("mid_rst_d_ready",  32'(d_ready),  32'd0);
    check("mid_rst_paddr",    paddr,         32'h0);
    @(posedge clk); #1; reset = 1'b1;
    run_xfer("post_rst", 1'b0, 0, 32'h0000_0013, 32'h0000_0044, 1'b0, 32'h0, 4'h0,
             32'h0000_0013, 1'b0, 3, 1'b0, 1'b0);

    // Round-robin from a fresh reset: fetch, data, fetch
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    if_req = 1'b1; if_addr = 32'h0000_0200;
    d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h4000_0000; d_strb = 4'hF;
    run_xfer("rr0", 1'b0, 0, 32'hA5A5_0001, 32'h0000_0200, 1'b0, 32'h0, 4'h0,
             32'hA5A5_0001, 1'b0, 3, 1'b0, 1'b0);
    @(posedge clk); #1; if_req = 1'b1;
    run_xfer("rr1", 1'b1, 0, 32'hA5A5_0002, 32'h4000_0000, 1'b0, 32'h0, 4'h0,
             32'hA5A5_0002, 1'b0, 3, 1'b0, 1'b0);
    @(posedge clk); #1; d_req = 1'b1;
    run_xfer("rr2", 1'b0, 0, 32'hA5A5_0003, 32'h0000_0200, 1'b0, 32'h0, 4'h0,
             32'hA5A5_0003, 1'b0, 3, 1'b0, 1'b0);
    d_req = 1'b0;

    repeat (4) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
